// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame layout and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_RECOVER
  } ps2_state_e;

  // Falls 1-8 carry data, then parity, stop, and the device ACK on the last one.
  localparam int FRAME_FALLS = 11;
  localparam int PARITY_FALL = FRAME_FALLS - 2;
  localparam int STOP_FALL   = FRAME_FALLS - 1;

  localparam int DEF_INHIBIT_CYCLES = 10000;
  localparam int DEF_TIMEOUT_CYCLES = 2000000;
  localparam int DEF_TO_W           = 21;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pad with falling-edge detect.
// Shared with the receive path so both sides see identical edge timing.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Reset to 1 so an idle (pulled-up) line never looks like a fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte
// on device clock falls, sample the ACK, then wait for the bus to go idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = DEF_TO_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam logic [TO_W-1:0] INH_LAST = TO_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [3:0]      fall_cnt_q, fall_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            data_meta_q, data_meta_d;
  logic            data_sync_q, data_sync_d;

  logic       clk_sync;
  logic       clk_fall;
  logic [3:0] fall_num;
  logic       in_frame;

  ps2_sync_edge u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_clk_in),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  assign fall_num = fall_cnt_q + 4'd1;
  assign in_frame = (state_q == ST_RTS) || (state_q == ST_SEND) ||
                    (state_q == ST_ACK) || (state_q == ST_RECOVER);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fall_cnt_d    = fall_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    data_meta_d   = ps2_data_in;
    data_sync_d   = data_meta_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d    = tx_data;
          parity_d   = odd_parity(tx_data);
          cnt_d      = '0;
          fall_cnt_d = '0;
          clk_oe_d   = 1'b1;
          data_oe_d  = 1'b0;
          state_d    = ST_INHIBIT;
        end
      end
      // Start bit goes out together with the clock release.
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_RTS;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_RTS, ST_SEND: begin
        cnt_d = cnt_q + TO_W'(1);
        if (clk_fall) begin
          fall_cnt_d = fall_num;
          state_d    = ST_SEND;
          if (fall_num < 4'(PARITY_FALL)) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (fall_num == 4'(PARITY_FALL)) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        cnt_d = cnt_q + TO_W'(1);
        if (clk_fall) begin
          fall_cnt_d = fall_num;
          if (data_sync_q) ack_err_d = 1'b1;
          else             done_d    = 1'b1;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        cnt_d = cnt_q + TO_W'(1);
        if (clk_sync && data_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout wins over any fall seen in the same cycle.
    if (in_frame && (cnt_q == TO_LAST)) begin
      state_d       = ST_IDLE;
      cnt_d         = '0;
      clk_oe_d      = 1'b0;
      data_oe_d     = 1'b0;
      done_d        = 1'b0;
      ack_err_d     = 1'b0;
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fall_cnt_q    <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      data_meta_q   <= 1'b1;
      data_sync_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fall_cnt_q    <= fall_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
      data_meta_q   <= data_meta_d;
      data_sync_q   <= data_sync_d;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock and ACK,
// and each frame on the pad is compared with the byte's expected line levels.
module tb_ps2_host_tx;

  localparam int INH   = 40;
  localparam int TMO   = 2000;
  localparam int TOW   = 21;
  localparam int HALF  = 20;
  localparam int FALLS = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  wire ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  wire ps2_data_in = ~(ps2_data_oe | dev_data_low);

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int ack_seen = 0;
  int to_seen = 0;
  int accepts = 0;
  logic scramble = 1'b0;
  int sg;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (TOW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout_err (timeout_err)
  );

  always @(negedge clk) begin
    if (done)        done_seen++;
    if (ack_err)     ack_seen++;
    if (timeout_err) to_seen++;
  end

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) accepts++;
  end

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line level seen by the device after falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] expectedLine(input logic [7:0] b);
    int ones = 0;
    logic [9:0] l;
    for (int i = 0; i < 8; i++) begin
      l[i] = b[i];
      ones += int'(b[i]);
    end
    l[8] = ((ones % 2) == 0);
    l[9] = 1'b1;
    return l;
  endfunction

  task applyStimulus(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task checkInhibit();
    int n;
    logic saw_data;
    n = 0;
    saw_data = 1'b0;
    while (ps2_clk_oe && n < INH + 20) begin
      if (ps2_data_oe) saw_data = 1'b1;
      n++;
      @(negedge clk);
    end
    checkOutput("inhibit_len", n, INH);
    checkOutput("inhibit_data_released", saw_data, 0);
    checkOutput("rts_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  task deviceRun(input int nfalls, input logic ack, output logic [9:0] line);
    line = '0;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == FALLS) dev_data_low = ack;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i < FALLS) line[i-1] = ps2_data_in;
      if (i < nfalls) dev_clk_low = 1'b0;
    end
    if (nfalls == FALLS) begin
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task waitIdle();
    int g;
    g = 0;
    while (busy && g < 6000) begin
      @(negedge clk);
      g++;
    end
    checkOutput("return_idle", busy, 0);
    checkOutput("tx_ready", tx_ready, 1);
  endtask

  task sendWithDevice(input logic [7:0] b, input logic ack);
    int d0, a0, t0;
    logic [9:0] line;
    d0 = done_seen; a0 = ack_seen; t0 = to_seen;
    applyStimulus(b);
    checkInhibit();
    deviceRun(FALLS, ack, line);
    checkOutput("frame_bits", line, expectedLine(b));
    waitIdle();
    checkOutput("done_count", done_seen - d0, ack ? 1 : 0);
    checkOutput("ack_err_count", ack_seen - a0, ack ? 0 : 1);
    checkOutput("timeout_count", to_seen - t0, 0);
  endtask

  task sendNoClock(input logic [7:0] b);
    int d0, a0, t0, j;
    d0 = done_seen; a0 = ack_seen; t0 = to_seen;
    applyStimulus(b);
    checkInhibit();
    j = 0;
    while (!timeout_err && j < TMO + 50) begin
      @(negedge clk);
      j++;
    end
    checkOutput("timeout_latency", j, TMO);
    checkOutput("timeout_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    checkOutput("timeout_idle", busy, 0);
    @(negedge clk);
    checkOutput("timeout_count", to_seen - t0, 1);
    checkOutput("timeout_other", (done_seen - d0) + (ack_seen - a0), 0);
  endtask

  initial begin
    int d0, a0, t0, acc0;
    logic [7:0] a;
    logic [9:0] line;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err, tx_ready},
                7'b0000001);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    sendWithDevice(8'hED, 1'b1);
    sendWithDevice(8'h07, 1'b0);
    sendNoClock(8'hF4);

    // Reset in the middle of a frame, after fall 5.
    d0 = done_seen; a0 = ack_seen; t0 = to_seen;
    applyStimulus(8'hFF);
    checkInhibit();
    deviceRun(5, 1'b0, line);
    checkOutput("partial_bits", line[4:0], 5'h1F);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("reset_no_pulse", (done_seen - d0) + (ack_seen - a0) + (to_seen - t0), 0);
    checkOutput("reset_idle", busy, 0);
    sendWithDevice(8'h00, 1'b1);

    // tx_valid held high with tx_data changing while the transfer runs.
    d0 = done_seen; acc0 = accepts;
    a = 8'($urandom);
    @(negedge clk);
    tx_data  = a;
    tx_valid = 1'b1;
    @(negedge clk);
    scramble = 1'b1;
    fork
      begin
        sg = 0;
        while (scramble && sg < 4000) begin
          @(negedge clk);
          sg++;
          if (done) begin
            tx_valid = 1'b0;
            scramble = 1'b0;
          end else begin
            tx_data = 8'($urandom);
          end
        end
        tx_valid = 1'b0;
        scramble = 1'b0;
      end
    join_none
    checkInhibit();
    deviceRun(FALLS, 1'b1, line);
    checkOutput("hold_frame_bits", line, expectedLine(a));
    waitIdle();
    checkOutput("hold_accepts", accepts - acc0, 1);
    checkOutput("hold_done", done_seen - d0, 1);

    for (int k = 0; k < 6; k++) begin
      sendWithDevice(8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, the send side of the existing keyboard receive path.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives open-drain PS/2 clock and data through active-high pull-low enables.
- Sits beside the keyboard receiver on the same ps2_clk/ps2_data pads. Top level muxes pad tristates.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles PS/2 clock is held low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: max clk cycles from clock release to ACK (20 ms at 100 MHz).
- TO_W, 21: width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- tx_data, input, 8: command byte.
- tx_valid, input, 1: request to send tx_data.
- tx_ready, output, 1: high only in IDLE; a transfer starts when tx_valid and tx_ready are both high.
- ps2_clk_in, input, 1: PS/2 clock pad read-back, asynchronous.
- ps2_data_in, input, 1: PS/2 data pad read-back, asynchronous.
- ps2_clk_oe, output, 1: 1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe, output, 1: 1 = pull PS/2 data low; 0 = release.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the device ACKed (data sampled low).
- ack_err, output, 1: one-cycle pulse when ACK was sampled high.
- timeout_err, output, 1: one-cycle pulse when TIMEOUT_CYCLES elapsed.

Behaviour:
- Reset values:
  - ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, done = 0, ack_err = 0, timeout_err = 0.
  - tx_ready = 1, state = IDLE, counters cleared.
  - Reset mid-transfer releases both lines immediately (asynchronous).
- Input sync:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer (reset to 1).
  - fall = sync_prev & ~sync_cur on the synchronized clock.
- Accept:
  - In IDLE with tx_valid = 1, latch tx_data into a shift register and compute parity = ~^tx_data (odd).
  - Clear bit counter and cycle counter; go to INHIBIT.
  - tx_valid is ignored while busy.
- INHIBIT:
  - ps2_clk_oe = 1; count INHIBIT_CYCLES.
  - On the last cycle, set ps2_data_oe = 1 (start bit = 0); go to RTS.
- RTS:
  - ps2_clk_oe = 0, ps2_data_oe stays 1; cycle counter restarts for timeout.
  - Frame sequence is keyed on device clock falling edges, numbered 1 to 11.
- SEND, falls 1–8:
  - On fall n, drive bit n-1 of tx_data, LSB first.
  - ps2_data_oe = ~bit (bit 1 releases the line, bit 0 pulls it low).
- Fall 9: drive parity, ps2_data_oe = ~parity.
- Fall 10: stop bit, ps2_data_oe = 0 (released); go to ACK.
- ACK:
  - On fall 11, sample synchronized data.
  - 0 -> done pulse; 1 -> ack_err pulse.
  - Either way go to RECOVER.
- RECOVER:
  - Wait until synchronized clock and data are both 1, then return to IDLE.
  - The timeout counter keeps running here too.
- Timeout:
  - Applies in RTS, SEND, ACK and RECOVER.
  - If the cycle counter reaches TIMEOUT_CYCLES, pulse timeout_err.
  - Release both lines and go to IDLE.
  - Timeout has priority over a fall in the same cycle.
- Falls during IDLE or INHIBIT are ignored; no receive-side decode happens here.
- done, ack_err and timeout_err are mutually exclusive and never pulse more than once per transfer.
- tx_ready rises the cycle after the return to IDLE.
- Per-edge timing:
  - Output enables change on the clk edge after the registered fall detection.
  - Nominal lag from pad edge to driven data is 3 clk cycles, well inside the PS/2 ~30 us low phase.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding (IDLE, INHIBIT, RTS, SEND, ACK, RECOVER),
  - frame constant FRAME_FALLS = 11,
  - the default cycle constants.
- One natural sub-module, ps2_sync_edge: 2-FF synchronizer plus falling-edge detect.
  - It is shared with the receive path, replacing its inline edge logic.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs.
  - Required: data line after falls 1–10 reads 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Required: done pulses once and tx_ready returns to 1.
- Send 0x07; device model never ACKs (leaves data high on fall 11).
  - Required: parity bit 0 and ack_err pulses once.
- Send 0xF4; device model provides no clock.
  - Required: timeout_err at TIMEOUT_CYCLES after clock release; ps2_clk_oe and ps2_data_oe both 0.
- Check inhibit timing on any send.
  - Required: ps2_clk_oe high for exactly INHIBIT_CYCLES before ps2_data_oe rises.
  - Required: ps2_clk_oe = 0 from the first RTS cycle.
- Assert rst after fall 5 of a 0xFF send.
  - Required: both oe outputs 0 asynchronously, busy 0, no status pulse.
  - Required: a following send of 0x00 (parity 1) completes with done.
- Hold tx_valid high with changing tx_data during a transfer.
  - Required: only the latched byte is transmitted and one transfer occurs per accept.
